// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_pkg
// Brief    : Shared types, constants and single-iteration step functions for
//            the iterative signed multiply/divide sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

  localparam int MD_W   = 32;
  localparam int ITER_W = $clog2(MD_W);

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2,
    DIV0   = 2'd3
  } state_t;

  // hi carries one guard bit so hi -/+ M cannot overflow for M = -2^(W-1)
  typedef struct packed {
    logic [MD_W:0]   hi;
    logic [MD_W-1:0] lo;
    logic            q1;
  } booth_t;

  typedef struct packed {
    logic [MD_W:0]   rem;
    logic [MD_W-1:0] quo;
  } rest_t;

  function automatic booth_t booth_step(input booth_t cur, input logic [MD_W-1:0] m);
    logic [MD_W:0] m_ext;
    logic [MD_W:0] sum;
    booth_t        nxt;
    m_ext = {m[MD_W-1], m};
    case ({cur.lo[0], cur.q1})
      2'b01:   sum = cur.hi + m_ext;
      2'b10:   sum = cur.hi - m_ext;
      default: sum = cur.hi;
    endcase
    nxt.hi = {sum[MD_W], sum[MD_W:1]};
    nxt.lo = {sum[0], cur.lo[MD_W-1:1]};
    nxt.q1 = cur.lo[0];
    return nxt;
  endfunction

  function automatic rest_t restore_step(input rest_t cur, input logic [MD_W-1:0] d);
    logic [MD_W:0] sh;
    rest_t         nxt;
    sh = (cur.rem << 1) | {{MD_W{1'b0}}, cur.quo[MD_W-1]};
    if (sh >= {1'b0, d}) begin
      nxt.rem = sh - {1'b0, d};
      nxt.quo = {cur.quo[MD_W-2:0], 1'b1};
    end else begin
      nxt.rem = sh;
      nxt.quo = {cur.quo[MD_W-2:0], 1'b0};
    end
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_sequencer
// Brief    : Iterative signed MULT (radix-2 Booth) / DIV (restoring) engine
//            with HI/LO load strobes and divide-by-zero flag.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_W,
  parameter int ITER  = WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             hi_write,
  output logic             lo_write
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ITER_W-1:0]  r_cnt;
  logic               r_op;
  logic [WIDTH:0]     r_acc_hi;
  logic [WIDTH-1:0]   r_acc_lo;
  logic               r_q1;
  logic [WIDTH-1:0]   r_m;
  logic               r_neg_q;
  logic               r_neg_r;

  logic               r_busy;
  logic               r_done;
  logic               r_div0;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_accept;
  logic               w_last;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  booth_t             w_booth;
  rest_t              w_rest;
  logic [WIDTH-1:0]   w_hi_res;
  logic [WIDTH-1:0]   w_lo_res;

  assign w_accept = (r_state == IDLE) && start;
  assign w_last   = (r_state == RUN) && (r_cnt == '0);
  assign w_a_mag  = a_in[WIDTH-1] ? -a_in : a_in;
  assign w_b_mag  = b_in[WIDTH-1] ? -b_in : b_in;

  assign w_booth = booth_step('{hi: r_acc_hi, lo: r_acc_lo, q1: r_q1}, r_m);
  assign w_rest  = restore_step('{rem: r_acc_hi, quo: r_acc_lo}, r_m);

  // Result of the final iteration, sign-corrected for DIV (remainder follows dividend)
  always_comb begin
    w_hi_res = w_booth.hi[WIDTH-1:0];
    w_lo_res = w_booth.lo;
    if (r_op == OP_DIV) begin
      w_hi_res = r_neg_r ? -w_rest.rem[WIDTH-1:0] : w_rest.rem[WIDTH-1:0];
      w_lo_res = r_neg_q ? -w_rest.quo : w_rest.quo;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = ((op == OP_DIV) && (b_in == '0)) ? DIV0 : RUN;
        end
      end
      RUN: begin
        if (r_cnt == '0) begin
          w_state_nxt = FINISH;
        end
      end
      FINISH:  w_state_nxt = IDLE;
      DIV0:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_op     <= OP_MULT;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_q1     <= 1'b0;
      r_m      <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else if (w_accept) begin
      r_cnt    <= ITER_W'(ITER - 1);
      r_op     <= op;
      r_acc_hi <= '0;
      r_q1     <= 1'b0;
      r_neg_q  <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
      r_neg_r  <= a_in[WIDTH-1];
      if (op == OP_DIV) begin
        r_acc_lo <= w_a_mag;
        r_m      <= w_b_mag;
      end else begin
        r_acc_lo <= b_in;
        r_m      <= a_in;
      end
    end else if (r_state == RUN) begin
      r_cnt <= r_cnt - 1'b1;
      if (r_op == OP_DIV) begin
        r_acc_hi <= w_rest.rem;
        r_acc_lo <= w_rest.quo;
      end else begin
        r_acc_hi <= w_booth.hi;
        r_acc_lo <= w_booth.lo;
        r_q1     <= w_booth.q1;
      end
    end
  end

  // Status flags are registered from the next state so they align with it
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_div0 <= 1'b0;
      r_hi   <= '0;
      r_lo   <= '0;
    end else begin
      r_busy <= (w_state_nxt != IDLE);
      r_done <= (w_state_nxt == FINISH);
      r_div0 <= (w_state_nxt == DIV0);
      if (w_last) begin
        r_hi <= w_hi_res;
        r_lo <= w_lo_res;
      end
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign div_zero = r_div0;
  assign hi_write = r_done;
  assign lo_write = r_done;
  assign hi_out   = r_hi;
  assign lo_out   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_sequencer
// Brief    : Scoreboard bench for muldiv_sequencer with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         op    = 1'b0;
  logic [W-1:0] a_in  = '0;
  logic [W-1:0] b_in  = '0;
  logic         busy, done, div_zero, hi_write, lo_write;
  logic [W-1:0] hi_out, lo_out;

  muldiv_sequencer #(.WIDTH(W), .ITER(W)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a_in     (a_in),
    .b_in     (b_in),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi_out   (hi_out),
    .lo_out   (lo_out),
    .hi_write (hi_write),
    .lo_write (lo_write)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic         is_div0;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           t;
  } exp_t;

  exp_t  sb[$];
  exp_t  mon_e;
  int    cyc     = 0;
  int    n_tests = 0;
  int    n_fail  = 0;
  string cur_name = "reset";

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got 0x%0h, expected 0x%0h", cur_name, name, act, exp);
    end
  endtask

  // Monitor: any completion strobe must match the oldest outstanding request
  always @(negedge clock) begin
    if (reset && (done || div_zero || hi_write || lo_write)) begin
      check("wr_en", {hi_write, lo_write}, {done, done});
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s/unexpected: done=%b div_zero=%b with nothing pending", cur_name, done, div_zero);
      end else if (done || div_zero) begin
        mon_e = sb.pop_front();
        check("kind", {done, div_zero}, mon_e.is_div0 ? 2'b01 : 2'b10);
        check("latency", cyc, mon_e.is_div0 ? mon_e.t : mon_e.t + 32);
        check("hi_out", hi_out, mon_e.hi);
        check("lo_out", lo_out, mon_e.lo);
        check("busy_end", busy, 1'b1);
      end
    end
  end

  always @(posedge clock) begin
    if (reset && !busy) begin
      assert (!$isunknown(start)) else begin
        n_fail++;
        $display("FAIL start_x: start is 0x%0h in idle", start);
      end
    end
  end

  task automatic issue(input string name, input logic o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic d0,
                       input logic [W-1:0] eh, input logic [W-1:0] el);
    exp_t e;
    @(negedge clock);
    cur_name = name;
    start = 1'b1; op = o; a_in = a; b_in = b;
    e.is_div0 = d0; e.hi = eh; e.lo = el; e.t = cyc + 1;
    sb.push_back(e);
    @(negedge clock);
    start = 1'b0; op = 1'b0; a_in = '1; b_in = '0;
    check("busy_start", busy, 1'b1);
  endtask

  task automatic wait_end();
    int n = 0;
    while (!(done || div_zero) && n < 60) begin
      @(negedge clock);
      n++;
    end
    if (!(done || div_zero)) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s/timeout: no done or div_zero within 60 cycles, got busy=%b", cur_name, busy);
      sb.delete();
    end
  endtask

  task automatic do_op(input string name, input logic o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el);
    issue(name, o, a, b, 1'b0, eh, el);
    wait_end();
  endtask

  initial begin
    exp_t e;
    repeat (2) @(negedge clock);
    check("rst_flags", {busy, done, div_zero, hi_write, lo_write}, 5'b0);
    check("rst_hilo", {hi_out, lo_out}, 64'h0);
    reset = 1'b1;

    do_op("t1_mult_7xm3",  OP_MULT, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB);
    do_op("t2_mult_min2",  OP_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    do_op("mult_m1xm1",    OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001);
    do_op("t3_div_m7d2",   OP_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    do_op("t3_div_wrap",   OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    do_op("div_m100d7",    OP_DIV,  32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFF2);
    do_op("div_100dm7",    OP_DIV,  32'd100,      32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2);

    do_op("t4_prior",      OP_DIV,  32'h451,      32'h20,       32'h11,       32'h22);
    issue("t4_div0",       OP_DIV,  32'd100,      32'd0,        1'b1, 32'h11, 32'h22);
    wait_end();
    @(negedge clock);
    check("t4_idle", {busy, done, div_zero, hi_write}, 4'b0);
    check("t4_hold", {hi_out, lo_out}, {32'h11, 32'h22});

    // Request held high with new operands during RUN: ignored, then accepted once
    @(negedge clock);
    cur_name = "t5_mult_3x5";
    start = 1'b1; op = OP_MULT; a_in = 32'd3; b_in = 32'd5;
    e.is_div0 = 1'b0; e.hi = 32'd0; e.lo = 32'd15; e.t = cyc + 1;
    sb.push_back(e);
    @(negedge clock);
    op = OP_DIV; a_in = 32'd100; b_in = 32'd7;
    wait_end();
    e.is_div0 = 1'b0; e.hi = 32'd2; e.lo = 32'd14; e.t = cyc + 2;
    sb.push_back(e);
    @(negedge clock);
    @(negedge clock);
    cur_name = "t5_held_div";
    start = 1'b0; op = 1'b0; a_in = '0; b_in = '0;
    wait_end();

    // Asynchronous reset in the middle of a divide
    @(negedge clock);
    cur_name = "t6_abort";
    start = 1'b1; op = OP_DIV; a_in = 32'd1000; b_in = 32'd7;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(posedge clock);
    #2 reset = 1'b0;
    #1;
    check("abort_flags", {busy, done, div_zero}, 3'b0);
    check("abort_hilo", {hi_out, lo_out}, 64'h0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    repeat (40) @(negedge clock);
    check("abort_quiet", {busy, hi_out, lo_out}, 65'h0);
    do_op("t6_after",      OP_DIV,  32'd1000,     32'd7,        32'd6,        32'd142);

    repeat (3) @(negedge clock);
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL leftover: %0d expected completions never seen, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, got no finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
